// File: rtl/hdmi_island_scheduler.sv
// hdmi_island_scheduler
// Schedules one HDMI data island per line inside horizontal blanking. Each
// packet slot goes to one packet source, and the module drives the framing
// strobes that the TERC4 data-island serializer needs.
//
// Ports
//   i_pixclk     pixel clock
//   i_reset      asynchronous active-high reset
//   i_hSync      horizontal sync, either polarity (only its transitions matter)
//   i_blank      1 during blanking
//   i_enable     0 prevents new islands; an island already running completes
//   i_req        level request per source, held until o_ack
//   o_island     high from the first preamble cycle through the last trailing guard cycle
//   o_preamble   high for the 8-cycle preamble
//   o_guard      high for the 2-cycle leading and 2-cycle trailing guard bands
//   o_pkt_first  high on the first cycle of each packet slot
//   o_grant      one-hot owner of the current slot, 0 outside slots
//   o_ack        one-cycle pulse to the owner on the last cycle of its slot
//   o_abort      one-cycle pulse when blanking ends inside an island
//
// Configuration macro HDMI_ISLAND_RR_EN
//   defined   : source 0 has strict priority; sources 1..NREQ-1 share slots
//               round-robin, starting at a pointer
//   undefined : fixed priority, and the lowest requesting index wins
module hdmi_island_scheduler #(
    parameter int NREQ     = 4,
    parameter int LEAD_DLY = 4,
    parameter int MAX_PKT  = 2,
    parameter int PKT_LEN  = 32
) (
    input  logic            i_pixclk,
    input  logic            i_reset,
    input  logic            i_hSync,
    input  logic            i_blank,
    input  logic            i_enable,
    input  logic [NREQ-1:0] i_req,
    output logic            o_island,
    output logic            o_preamble,
    output logic            o_guard,
    output logic            o_pkt_first,
    output logic [NREQ-1:0] o_grant,
    output logic [NREQ-1:0] o_ack,
    output logic            o_abort
);

    // One counter covers every phase, so it is sized for the longest phase.
    localparam int CNT_MAX = (PKT_LEN > LEAD_DLY) ? ((PKT_LEN > 8) ? PKT_LEN : 8)
                                                  : ((LEAD_DLY > 8) ? LEAD_DLY : 8);
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(LEAD_DLY - 1);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] GRD_LAST  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ACK_AT    = CNT_W'(PKT_LEN - 2);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(PKT_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT     = 3'd1,
        S_PREAMBLE = 3'd2,
        S_GUARD_L  = 3'd3,
        S_PACKET   = 3'd4,
        S_GUARD_T  = 3'd5
    } state_t;

    state_t          state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [4:0]      pktCnt_r;
    logic            armed_r;
    logic            hSyncPrev_r;
    logic            blankPrev_r;

    logic            hsEdge_s;
    logic            blankRise_s;
    logic            blankFall_s;
    logic [NREQ-1:0] elig_s;
    logic [NREQ-1:0] winner_s;
    logic [4:0]      pktCntNext_s;
    logic            morePkts_s;

`ifdef HDMI_ISLAND_RR_EN
    localparam int PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0] rrPtr_r;

    // Source 0 wins outright. Otherwise the search starts at the pointer and
    // scans upward, wrapping from NREQ-1 back to 1 (never to 0).
    function automatic logic [NREQ-1:0] pickWinner(input logic [NREQ-1:0] elig,
                                                   input logic [PTR_W-1:0] ptr);
        logic [NREQ-1:0] win;
        logic            found;
        int              cand;
        win   = {NREQ{1'b0}};
        found = 1'b0;
        if (elig[0]) begin
            win[0] = 1'b1;
        end else begin
            for (int s = 0; s < NREQ - 1; s++) begin
                cand = int'(ptr) + s;
                if (cand > NREQ - 1) begin
                    cand = cand - (NREQ - 1);
                end else begin
                    cand = cand;
                end
                for (int i = 1; i < NREQ; i++) begin
                    if (!found && (i == cand) && elig[i]) begin
                        win[i] = 1'b1;
                        found  = 1'b1;
                    end else begin
                        found = found;
                    end
                end
            end
        end
        return win;
    endfunction

    // The pointer moves just past a non-zero winner. A grant to source 0 leaves it in place.
    function automatic logic [PTR_W-1:0] ptrAfter(input logic [NREQ-1:0] win,
                                                  input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        nxt = ptr;
        for (int i = 1; i < NREQ; i++) begin
            if (win[i]) begin
                nxt = (i == NREQ - 1) ? PTR_W'(1) : PTR_W'(i + 1);
            end else begin
                nxt = nxt;
            end
        end
        return nxt;
    endfunction

    assign winner_s = pickWinner(elig_s, rrPtr_r);
`else
    // Fixed priority: the lowest set index wins.
    function automatic logic [NREQ-1:0] pickWinner(input logic [NREQ-1:0] elig);
        logic [NREQ-1:0] win;
        logic            found;
        win   = {NREQ{1'b0}};
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && elig[i]) begin
                win[i] = 1'b1;
                found  = 1'b1;
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

    assign winner_s = pickWinner(elig_s);
`endif

    assign hsEdge_s     = i_hSync ^ hSyncPrev_r;
    assign blankRise_s  = i_blank & ~blankPrev_r;
    assign blankFall_s  = ~i_blank & blankPrev_r;
    // The owner of the slot that is ending cannot win the next slot back to back.
    assign elig_s       = (state_r == S_PACKET) ? (i_req & ~o_grant) : i_req;
    assign pktCntNext_s = pktCnt_r + 5'd1;
    assign morePkts_s   = (pktCntNext_s < 5'(MAX_PKT)) && (|winner_s);

    // Registered copies of hSync and blank, used for edge detection
    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            hSyncPrev_r <= 1'b0;
            blankPrev_r <= 1'b0;
        end else begin
            hSyncPrev_r <= i_hSync;
            blankPrev_r <= i_blank;
        end
    end

    // Island sequencer: phase counting, slot arbitration and registered framing outputs
    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            state_r     <= S_IDLE;
            cnt_r       <= CNT_ZERO;
            pktCnt_r    <= 5'd0;
            armed_r     <= 1'b0;
            o_island    <= 1'b0;
            o_preamble  <= 1'b0;
            o_guard     <= 1'b0;
            o_pkt_first <= 1'b0;
            o_grant     <= {NREQ{1'b0}};
            o_ack       <= {NREQ{1'b0}};
            o_abort     <= 1'b0;
`ifdef HDMI_ISLAND_RR_EN
            rrPtr_r     <= PTR_W'(1);
`endif
        end else begin
            o_pkt_first <= 1'b0;
            o_ack       <= {NREQ{1'b0}};
            o_abort     <= 1'b0;
            if (blankRise_s) begin
                armed_r <= 1'b1;
            end
            if ((state_r != S_IDLE) && blankFall_s) begin
                // Blanking ended early: drop everything and do not ack the partial slot.
                state_r    <= S_IDLE;
                cnt_r      <= CNT_ZERO;
                pktCnt_r   <= 5'd0;
                armed_r    <= 1'b0;
                o_island   <= 1'b0;
                o_preamble <= 1'b0;
                o_guard    <= 1'b0;
                o_grant    <= {NREQ{1'b0}};
                o_abort    <= 1'b1;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        // An edge arriving in the same cycle as the blank rise still triggers.
                        if (hsEdge_s && (armed_r || blankRise_s)) begin
                            state_r <= S_WAIT;
                            armed_r <= 1'b0;
                            cnt_r   <= CNT_ZERO;
                        end
                    end
                    S_WAIT: begin
                        if (cnt_r == WAIT_LAST) begin
                            cnt_r <= CNT_ZERO;
                            if (i_enable && (|i_req)) begin
                                state_r    <= S_PREAMBLE;
                                o_island   <= 1'b1;
                                o_preamble <= 1'b1;
                            end else begin
                                state_r <= S_IDLE;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    S_PREAMBLE: begin
                        if (cnt_r == PRE_LAST) begin
                            state_r    <= S_GUARD_L;
                            cnt_r      <= CNT_ZERO;
                            o_preamble <= 1'b0;
                            o_guard    <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    S_GUARD_L: begin
                        if (cnt_r == GRD_LAST) begin
                            cnt_r    <= CNT_ZERO;
                            pktCnt_r <= 5'd0;
                            if (|winner_s) begin
                                state_r     <= S_PACKET;
                                o_guard     <= 1'b0;
                                o_grant     <= winner_s;
                                o_pkt_first <= 1'b1;
`ifdef HDMI_ISLAND_RR_EN
                                rrPtr_r     <= ptrAfter(winner_s, rrPtr_r);
`endif
                            end else begin
                                // Every request dropped: go straight to the trailing guard band.
                                state_r <= S_GUARD_T;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    S_PACKET: begin
                        if (cnt_r == SLOT_LAST) begin
                            cnt_r    <= CNT_ZERO;
                            pktCnt_r <= pktCntNext_s;
                            if (morePkts_s) begin
                                o_grant     <= winner_s;
                                o_pkt_first <= 1'b1;
`ifdef HDMI_ISLAND_RR_EN
                                rrPtr_r     <= ptrAfter(winner_s, rrPtr_r);
`endif
                            end else begin
                                state_r <= S_GUARD_T;
                                o_grant <= {NREQ{1'b0}};
                                o_guard <= 1'b1;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                            // Registered ack: set one cycle early so it lands on the slot's last cycle.
                            if (cnt_r == ACK_AT) begin
                                o_ack <= o_grant;
                            end
                        end
                    end
                    S_GUARD_T: begin
                        if (cnt_r == GRD_LAST) begin
                            state_r  <= S_IDLE;
                            cnt_r    <= CNT_ZERO;
                            o_island <= 1'b0;
                            o_guard  <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    default: begin
                        state_r    <= S_IDLE;
                        cnt_r      <= CNT_ZERO;
                        pktCnt_r   <= 5'd0;
                        o_island   <= 1'b0;
                        o_preamble <= 1'b0;
                        o_guard    <= 1'b0;
                        o_grant    <= {NREQ{1'b0}};
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Testbench for hdmi_island_scheduler. Each blanking line is driven and every
// output is compared cycle by cycle against a timeline worked out from the
// island rules: trigger offset, phase lengths and slot owners picked by priority.
module tb_hdmi_island_scheduler;

    localparam int NREQ = 4;
    localparam int LEAD = 4;
    localparam int MAXP = 2;
    localparam int PL   = 32;
    localparam int K    = 90;

    logic            clk;
    logic            rst;
    logic            hs;
    logic            blank;
    logic            en;
    logic [NREQ-1:0] req;
    logic            island;
    logic            preamble;
    logic            guard;
    logic            pktFirst;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] ack;
    logic            abort;

    int              nChecks;
    int              nFails;
    int              lineId;
    int              ptr;
    logic [NREQ-1:0] pending;

    hdmi_island_scheduler #(
        .NREQ(NREQ), .LEAD_DLY(LEAD), .MAX_PKT(MAXP), .PKT_LEN(PL)
    ) dut (
        .i_pixclk(clk), .i_reset(rst), .i_hSync(hs), .i_blank(blank),
        .i_enable(en), .i_req(req), .o_island(island), .o_preamble(preamble),
        .o_guard(guard), .o_pkt_first(pktFirst), .o_grant(grant), .o_ack(ack),
        .o_abort(abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] outVec();
        return {island, preamble, guard, pktFirst, grant, ack, abort};
    endfunction

    // Priority rule: in round-robin mode source 0 first, then the requester nearest at or after ptr
    function automatic int pick(input logic [NREQ-1:0] m, input int p);
        int best;
        int bd;
        int d;
        best = -1;
        bd   = NREQ * 2;
`ifdef HDMI_ISLAND_RR_EN
        if (m[0]) return 0;
        for (int i = 1; i < NREQ; i++) begin
            d = (i - p + (NREQ - 1)) % (NREQ - 1);
            if (m[i] && d < bd) begin
                bd   = d;
                best = i;
            end
        end
`else
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (m[i]) best = i;
        end
        d  = 0;
        bd = d;
`endif
        return best;
    endfunction

    task automatic run_line(input logic [NREQ-1:0] addReq, input logic enLine, input bit simul,
                            input int fallAt, input int resetAt, input int enDropAt);
        logic [NREQ-1:0] owners [0:MAXP-1];
        int              ptrBefore [0:MAXP-1];
        logic [NREQ-1:0] pend;
        logic [12:0]     got;
        logic [12:0]     exp;
        logic            eIsl, ePre, eGrd, eFirst;
        logic [NREQ-1:0] eGrant, eAck;
        int              n, w, pre, last, s, islCnt;
        bit              go;
        lineId++;
        pending = pending | addReq;
        req     = pending;
        en      = enLine;
        go      = enLine && (pending != 0);
        n       = 0;
        pend    = pending;
        for (int j = 0; j < MAXP; j++) begin
            owners[j]    = '0;
            ptrBefore[j] = ptr;
            if (go && pend != 0) begin
                w         = pick(pend, ptr);
                owners[j] = NREQ'(1) << w;
`ifdef HDMI_ISLAND_RR_EN
                if (w != 0) ptr = (w == NREQ - 1) ? 1 : w + 1;
`endif
                pend = pend & ~owners[j];
                n++;
            end
        end
        pre  = 1 + LEAD;
        last = pre + 11 + PL * n;
        // A slot that had not started before the abort was never granted, so its pointer move is undone
        if (fallAt > 0) begin
            for (int j = n - 1; j >= 0; j--) begin
                if (pre + 10 + PL * j >= fallAt + 1) ptr = ptrBefore[j];
            end
        end
        if (!simul) begin
            @(negedge clk);
            blank = 1'b1;
            repeat (2) @(negedge clk);
        end else begin
            @(negedge clk);
            blank = 1'b1;
        end
        hs     = ~hs;
        islCnt = 0;
        for (int k = 1; k <= K; k++) begin
            @(negedge clk);
            got    = outVec();
            eIsl   = go && k >= pre && k <= last;
            ePre   = go && k >= pre && k <= pre + 7;
            eGrd   = go && (k == pre + 8 || k == pre + 9 || k == last - 1 || k == last);
            eFirst = 1'b0;
            eGrant = '0;
            eAck   = '0;
            for (int j = 0; j < n; j++) begin
                s = pre + 10 + PL * j;
                if (k >= s && k <= s + PL - 1) eGrant = owners[j];
                if (k == s) eFirst = 1'b1;
                if (k == s + PL - 1) eAck = owners[j];
            end
            exp = {eIsl, ePre, eGrd, eFirst, eGrant, eAck, 1'b0};
            if (fallAt > 0 && k == fallAt + 1) exp = 13'd1;
            if (fallAt > 0 && k > fallAt + 1) exp = 13'd0;
            nChecks++;
            if (got !== exp) begin
                nFails++;
                $display("FAIL line%0d k=%0d {isl,pre,grd,first,grant,ack,abort} got %b expected %b",
                         lineId, k, got, exp);
            end
            if (island === 1'b1) islCnt++;
            pending = pending & ~ack;
            req     = pending;
            if (k == fallAt) blank = 1'b0;
            if (k == enDropAt) en = 1'b0;
            if (k == 84) hs = ~hs;
            if (k == resetAt) begin
                rst = 1'b1;
                #1;
                nChecks++;
                if (outVec() !== 13'd0) begin
                    nFails++;
                    $display("FAIL line%0d reset_mid outputs got %b expected 0", lineId, outVec());
                end
                @(posedge clk);
                @(negedge clk);
                rst   = 1'b0;
                blank = 1'b0;
                ptr   = 1;
                break;
            end
        end
        if (fallAt == 0 && resetAt == 0) begin
            nChecks++;
            if (islCnt != (go ? 12 + PL * n : 0)) begin
                nFails++;
                $display("FAIL line%0d island_len got %0d expected %0d", lineId, islCnt,
                         go ? 12 + PL * n : 0);
            end
        end
        blank = 1'b0;
        en    = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) begin
            if (pending != 0) run_line('0, 1'b1, 1'b0, 0, 0, 0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        nChecks++;
        if (outVec() !== 13'd0) begin
            nFails++;
            $display("FAIL reset_state got %b expected 0", outVec());
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        nChecks++;
        if (outVec() !== 13'd0) begin
            nFails++;
            $display("FAIL post_reset_idle got %b expected 0", outVec());
        end
    endtask

    task automatic test_single();
        run_line(4'b0001, 1'b1, 1'b0, 0, 0, 0);
    endtask

    task automatic test_priority_sequence();
        for (int i = 0; i < 3; i++) run_line(4'b1111, 1'b1, 1'b0, 0, 0, 0);
    endtask

    task automatic test_abort();
        drain();
        run_line(4'b0010, 1'b1, 1'b0, 1 + LEAD + 10 + 10, 0, 0);
        run_line(4'b0000, 1'b1, 1'b0, 0, 0, 0);
    endtask

    task automatic test_no_island();
        drain();
        run_line(4'b0001, 1'b0, 1'b0, 0, 0, 0);
        drain();
        run_line(4'b0000, 1'b1, 1'b0, 0, 0, 0);
    endtask

    task automatic test_simultaneous();
        run_line(4'b0100, 1'b1, 1'b1, 0, 0, 0);
    endtask

    task automatic test_enable_drop();
        run_line(4'b1010, 1'b1, 1'b0, 0, 0, 20);
    endtask

    task automatic test_reset_mid();
        drain();
        run_line(4'b1001, 1'b1, 1'b0, 0, 25, 0);
        run_line(4'b0000, 1'b1, 1'b0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [NREQ-1:0] r;
        logic            e;
        for (int i = 0; i < 8; i++) begin
            r = NREQ'($urandom_range(0, 15));
            e = ($urandom_range(0, 3) != 0);
            run_line(r, e, 1'($urandom_range(0, 1)), 0, 0, ($urandom_range(0, 1) != 0) ? 30 : 0);
        end
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        lineId  = 0;
        ptr     = 1;
        pending = '0;
        hs      = 1'b0;
        blank   = 1'b0;
        en      = 1'b1;
        req     = '0;
        test_reset();
        test_single();
        test_priority_sequence();
        test_abort();
        test_no_island();
        test_simultaneous();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
